// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: issues instruction-memory requests at PCF, waits out a
// variable-latency response, holds data under decode back-pressure and throws
// away responses made stale by an execute-stage redirect.
module fetch_controller #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     MAX_WAIT  = 15,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCF,
  input  logic            PCSrcE,
  input  logic            StallD,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemGnt,
  input  logic            ImemRvalid,
  input  logic [XLEN-1:0] ImemRdata,
  output logic [XLEN-1:0] InstrF,
  output logic            InstrValidF,
  output logic            StallF,
  output logic            FlushD,
  output logic            TimeoutErr
);

  localparam int unsigned      CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_HOLD    = 3'd3,
    S_DISCARD = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [XLEN-1:0]  hold_q, hold_d;
  logic             timeout_q, timeout_d;

  // The request address is always the live PC; PCF is held while a request is pending.
  assign ImemAddr   = PCF;
  assign TimeoutErr = timeout_q;

  // Saturating increment of the response wait counter.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // State, wait counter, held instruction and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hold_q    <= NOP_INSTR;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and handshake outputs; a redirect always releases the PC and flushes decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    timeout_d   = timeout_q;
    ImemReq     = 1'b0;
    InstrF      = NOP_INSTR;
    InstrValidF = 1'b0;
    StallF      = 1'b1;
    FlushD      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        ImemReq = 1'b1;
        if (PCSrcE) begin
          StallF = 1'b0;
          FlushD = 1'b1;
          // A grant in the redirect cycle belongs to the old PC and must be drained.
          if (ImemGnt) begin
            state_d = S_DISCARD;
            cnt_d   = '0;
          end
        end else if (ImemGnt) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end

      S_WAIT: begin
        if (ImemRvalid) begin
          if (PCSrcE) begin
            StallF  = 1'b0;
            FlushD  = 1'b1;
            state_d = S_REQ;
          end else begin
            InstrF      = ImemRdata;
            InstrValidF = 1'b1;
            hold_d      = ImemRdata;
            if (!StallD) begin
              StallF  = 1'b0;
              state_d = S_REQ;
            end else begin
              state_d = S_HOLD;
            end
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) timeout_d = 1'b1;
          if (PCSrcE) begin
            StallF  = 1'b0;
            FlushD  = 1'b1;
            state_d = S_DISCARD;
          end
        end
      end

      S_HOLD: begin
        if (PCSrcE) begin
          StallF  = 1'b0;
          FlushD  = 1'b1;
          state_d = S_REQ;
        end else begin
          InstrF      = hold_q;
          InstrValidF = 1'b1;
          if (!StallD) begin
            StallF  = 1'b0;
            state_d = S_REQ;
          end
        end
      end

      S_DISCARD: begin
        if (PCSrcE) begin
          StallF = 1'b0;
          FlushD = 1'b1;
        end
        if (ImemRvalid) begin
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) timeout_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
